// File: rtl/instr_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding and block geometry.
package instr_cache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } icache_state_e;

    localparam int unsigned BLOCK_BITS    = 128;
    localparam int unsigned WORD_SEL_BITS = 2;

endpackage

// File: rtl/instr_cache_word_sel.sv
// Selects one 32-bit instruction word out of a 4-word cache block; word 0 sits in bits [31:0].
module icache_word_sel
    import instr_cache_pkg::*;
(
    input  logic [BLOCK_BITS-1:0]    block_i,
    input  logic [WORD_SEL_BITS-1:0] sel_i,
    output logic [31:0]              word_o
);

    always_comb begin
        word_o = block_i[31:0];
        case (sel_i)
            2'd0: word_o = block_i[31:0];
            2'd1: word_o = block_i[63:32];
            2'd2: word_o = block_i[95:64];
            2'd3: word_o = block_i[127:96];
            default: word_o = block_i[31:0];
        endcase
    end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache with single-block refill FSM.
// Define ICACHE_PERF_CNT_EN to build the saturating hit/miss performance counters.
module instr_cache
    import instr_cache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_read,
    input  logic [31:0]           cpu_address,
    output logic [31:0]           cpu_instr,
    output logic                  busywait,
    output logic                  mem_read,
    output logic [27:0]           mem_address,
    input  logic [BLOCK_BITS-1:0] mem_readdata,
    input  logic                  mem_busywait,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int unsigned SETS     = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 28 - INDEX_BITS;

    icache_state_e state_q, state_d;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [1:0]            req_off;
    logic                  unused_addr_bits;

    logic [SETS-1:0]       valid_q;
    logic [TAG_BITS-1:0]   tag_mem_q  [SETS];
    logic [BLOCK_BITS-1:0] data_mem_q [SETS];

    logic [TAG_BITS-1:0]   cap_tag_q;
    logic [INDEX_BITS-1:0] cap_idx_q;
    logic [BLOCK_BITS-1:0] block_q;

    logic hit, cap_en, blk_en, fill_we;

    assign req_tag          = cpu_address[31:4+INDEX_BITS];
    assign req_idx          = cpu_address[3+INDEX_BITS:4];
    assign req_off          = cpu_address[3:2];
    assign unused_addr_bits = ^cpu_address[1:0];

    assign hit         = valid_q[req_idx] && (tag_mem_q[req_idx] == req_tag);
    assign mem_address = {cap_tag_q, cap_idx_q};
    // A reset landing on UPDATE must not commit the half-finished fill.
    assign fill_we     = (state_q == UPDATE) && !rst;

    always_comb begin
        state_d  = state_q;
        busywait = 1'b0;
        mem_read = 1'b0;
        cap_en   = 1'b0;
        blk_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_read && !hit) begin
                    busywait = 1'b1;
                    cap_en   = 1'b1;
                    state_d  = MEM_READ;
                end
            end
            MEM_READ: begin
                mem_read = 1'b1;
                busywait = 1'b1;
                if (!mem_busywait) begin
                    blk_en  = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busywait = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill_we) valid_q[cap_idx_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) begin
            cap_tag_q <= req_tag;
            cap_idx_q <= req_idx;
        end
        if (blk_en) block_q <= mem_readdata;
        if (fill_we) begin
            tag_mem_q[cap_idx_q]  <= cap_tag_q;
            data_mem_q[cap_idx_q] <= block_q;
        end
    end

    icache_word_sel u_word_sel (
        .block_i (data_mem_q[req_idx]),
        .sel_i   (req_off),
        .word_o  (cpu_instr)
    );

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        hit_fire;

    assign hit_fire = (state_q == IDLE) && cpu_read && hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_fire && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (cap_en && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: doc/instr_cache.md
INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 3, giving 2^INDEX_BITS direct-mapped sets (8 by default).
REQ-002 SHALL have port clk, input, 1, the system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port cpu_read, input, 1, fetch request from the fetch stage.
REQ-005 SHALL have port cpu_address, input, 32, byte PC; bits [1:0] ignored.
REQ-006 SHALL have port cpu_instr, output, 32, the fetched instruction word.
REQ-007 SHALL have port busywait, output, 1, stall to the PC and the IF/ID register; high means cpu_instr is not valid.
REQ-008 SHALL have port mem_read, output, 1, block-read request to instruction memory.
REQ-009 SHALL have port mem_address, output, 28, block address = cpu_address[31:4].
REQ-010 SHALL have port mem_readdata, input, 128, a 4-word block with word 0 in bits [31:0].
REQ-011 SHALL have port mem_busywait, input, 1, high while memory is servicing mem_read.
REQ-012 SHALL have ports hit_count and miss_count, output, 32 each, performance counters (see Configuration).

Function
REQ-013 SHALL decode the address as tag = [31:4+INDEX_BITS], index = [3+INDEX_BITS:4], word offset = [3:2].
REQ-014 SHALL store per set: valid bit, tag, and a 128-bit block.
REQ-015 SHALL implement FSM states IDLE, MEM_READ, UPDATE.
REQ-016 In IDLE with cpu_read=1 and a hit (valid and tag match), SHALL drive cpu_instr with the selected word and busywait=0 combinationally in the same cycle.
REQ-017 In IDLE with cpu_read=1 and a miss, SHALL drive busywait=1 combinationally, capture tag and index, and go to MEM_READ next cycle.
REQ-018 In IDLE with cpu_read=0, SHALL hold busywait=0 and mem_read=0, and SHALL leave the state unchanged.
REQ-019 In MEM_READ, SHALL drive mem_read=1, mem_address={captured tag, captured index}, and busywait=1, and SHALL remain there while mem_busywait=1.
REQ-020 In MEM_READ with mem_busywait=0, SHALL register mem_readdata and go to UPDATE.
REQ-021 In UPDATE, SHALL write the block, tag, and valid=1 to the captured index, hold busywait=1 and mem_read=0, then return to IDLE.
REQ-022 After return to IDLE, the request SHALL hit, so miss penalty = 2 cycles + memory latency.
REQ-023 SHALL fill using the captured address even if cpu_address changes during a miss; the CPU is required to hold the address while busywait=1.
REQ-024 A miss to a valid set SHALL overwrite it; no write-back is needed because the cache is read-only.
REQ-025 Per-set memories SHALL be written only in UPDATE.

Reset
REQ-026 rst=1 at a clock edge SHALL clear all valid bits, set the state to IDLE, and set mem_read=0.
REQ-027 After reset, busywait SHALL be 0 until a cpu_read miss occurs.
REQ-028 rst asserted in MEM_READ or UPDATE SHALL abort the fill without writing the set.
REQ-029 Tag and data arrays need not be reset.

Configuration
REQ-030 Macro ICACHE_PERF_CNT_EN defined: hit_count SHALL increment once per IDLE-cycle hit with cpu_read=1, and miss_count SHALL increment once per miss entry to MEM_READ.
REQ-031 Both counters SHALL saturate at 0xFFFFFFFF and SHALL be cleared by rst.
REQ-032 Macro undefined: hit_count and miss_count SHALL be constant 0, and no counter flops SHALL be synthesised.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, MEM_READ=2'd1, UPDATE=2'd2), BLOCK_BITS=128, and WORD_SEL_BITS=2.
REQ-034 One sub-module, icache_word_sel (128-to-32 mux on the offset), is natural; everything else stays in instr_cache.

Verification
REQ-035 Reset, then cpu_read=1 at 0x00000000 with mem latency 5 -> busywait=1 for 7 cycles, mem_read=1 for 5 cycles with mem_address=0x0000000, then hit with cpu_instr=mem_readdata[31:0].
REQ-036 After filling 0x00000000, read 0x0000000C -> hit with busywait=0 the same cycle and cpu_instr=mem_readdata[127:96].
REQ-037 Read 0x00000080 (same index 0, tag 1) after 0x00000000 -> miss with mem_address=0x0000008; a re-read of 0x00000000 then misses again.
REQ-038 rst pulse during MEM_READ -> next cycle IDLE and mem_read=0; re-read of the same address misses.
REQ-039 With ICACHE_PERF_CNT_EN defined, 1 miss then 3 hit cycles -> miss_count=1 and hit_count=4 (including the post-fill hit); without the macro, both stay 0.
REQ-040 cpu_read=0 for 10 cycles after reset -> busywait=0, mem_read=0, no state change.
